// File: rtl/ofs_fim_emif_avmm_burst_splitter_if.sv
// AVMM bus bundle shared by the upstream and EMIF sides
// of the burst splitter.
interface ofs_fim_emif_avmm_burst_splitter_if #(
  parameter int DATA_WIDTH = 576,
  parameter int ADDR_WIDTH = 27,
  parameter int BURST_W    = 7
);
  logic [ADDR_WIDTH-1:0]   address;
  logic [BURST_W-1:0]      burstcount;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, burstcount, read, write,
    output writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read, write,
    input  writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/ofs_fim_emif_avmm_burst_splitter.sv
// Splits AVMM bursts into aligned sub-bursts of at most
// M_MAX_BURST beats for an EMIF slave port.
module ofs_fim_emif_avmm_burst_splitter #(
  parameter int DATA_WIDTH  = 576,
  parameter int ADDR_WIDTH  = 27,
  parameter int S_BURST_W   = 7,
  parameter int M_MAX_BURST = 16,
  parameter int M_BURST_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  ofs_fim_emif_avmm_burst_splitter_if.slave  s_if,
  ofs_fim_emif_avmm_burst_splitter_if.master m_if,
  output logic [1:0] err_flags
);
  localparam int OFS_W = M_BURST_W - 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WR_BURST = 2'd1;
  localparam logic [1:0] RD_ISSUE = 2'd2;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [S_BURST_W-1:0]  cnt_t;

  localparam cnt_t ONE = cnt_t'(1);

  // Beats left before the next M_MAX_BURST boundary, capped by rem.
  function automatic cnt_t sub_len(addr_t a, cnt_t rem);
    cnt_t room;
    room = cnt_t'(M_MAX_BURST) - cnt_t'(a[OFS_W-1:0]);
    return (rem < room) ? rem : room;
  endfunction

  logic [1:0] state_q, state_d;
  addr_t      addr_q, addr_d;
  cnt_t       len_q, len_d;
  cnt_t       rem_q, rem_d;
  cnt_t       beat_q, beat_d;
  logic [1:0] err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic       rvalid_q;

  logic  bc_zero;
  cnt_t  s_cnt, s_len, a1_len, wr_nl, rd_nl;
  addr_t a1, nxt_addr;
  logic  s_wait, m_wr, m_rd;
  addr_t m_addr;
  cnt_t  m_bc;

  assign bc_zero  = (s_if.burstcount == '0);
  assign s_cnt    = bc_zero ? ONE : s_if.burstcount;
  assign s_len    = sub_len(s_if.address, s_cnt);
  assign a1       = s_if.address + addr_t'(1);
  assign a1_len   = sub_len(a1, s_cnt - ONE);
  assign nxt_addr = addr_q + addr_t'(len_q);
  assign wr_nl    = sub_len(nxt_addr, rem_q - ONE);
  assign rd_nl    = sub_len(nxt_addr, rem_q - len_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    rem_d   = rem_q;
    beat_d  = beat_q;
    err_d   = err_q;
    s_wait  = 1'b0;
    m_wr    = 1'b0;
    m_rd    = 1'b0;
    m_addr  = addr_q;
    m_bc    = len_q;
    if (s_if.read && s_if.write)
      err_d[1] = 1'b1;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (s_if.write) begin
          m_wr     = 1'b1;
          m_addr   = s_if.address;
          m_bc     = s_len;
          s_wait   = m_if.waitrequest;
          err_d[0] = err_q[0] | bc_zero;
          if (!m_if.waitrequest && s_cnt != ONE) begin
            state_d = WR_BURST;
            rem_d   = s_cnt - ONE;
            // A one-beat first sub-burst is already done.
            if (s_len == ONE) begin
              addr_d = a1;
              len_d  = a1_len;
              beat_d = a1_len;
            end else begin
              addr_d = s_if.address;
              len_d  = s_len;
              beat_d = s_len - ONE;
            end
          end
        end else if (s_if.read) begin
          err_d[0] = err_q[0] | bc_zero;
          state_d  = RD_ISSUE;
          addr_d   = s_if.address;
          rem_d    = s_cnt;
          len_d    = s_len;
        end
      end
      (state_q == WR_BURST): begin
        m_wr   = s_if.write;
        s_wait = m_if.waitrequest;
        if (s_if.write && !m_if.waitrequest) begin
          rem_d = rem_q - ONE;
          if (rem_q == ONE) begin
            state_d = IDLE;
          end else if (beat_q == ONE) begin
            addr_d = nxt_addr;
            len_d  = wr_nl;
            beat_d = wr_nl;
          end else begin
            beat_d = beat_q - ONE;
          end
        end
      end
      (state_q == RD_ISSUE): begin
        s_wait = 1'b1;
        m_rd   = 1'b1;
        if (!m_if.waitrequest) begin
          rem_d = rem_q - len_q;
          if (rem_q == len_q) begin
            state_d = IDLE;
          end else begin
            addr_d = nxt_addr;
            len_d  = rd_nl;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      rem_q    <= '0;
      beat_q   <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      rem_q    <= rem_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      rdata_q  <= m_if.readdata;
      rvalid_q <= m_if.readdatavalid;
    end
  end

  assign s_if.waitrequest   = ~rst_n | s_wait;
  assign s_if.readdata      = rdata_q;
  assign s_if.readdatavalid = rvalid_q;

  assign m_if.write      = rst_n & m_wr;
  assign m_if.read       = rst_n & m_rd;
  assign m_if.address    = rst_n ? m_addr : '0;
  assign m_if.burstcount = rst_n ? M_BURST_W'(m_bc) : '0;
  assign m_if.writedata  = s_if.writedata;
  assign m_if.byteenable = s_if.byteenable;

  assign err_flags = err_q;
endmodule

// File: tb/tb_ofs_fim_emif_avmm_burst_splitter.sv
// Bench for the EMIF AVMM burst splitter: directed table,
// wrap/error/reset sequences and randomized stall traffic.
module tb_ofs_fim_emif_avmm_burst_splitter;
  localparam int DW = 576;
  localparam int AW = 27;
  localparam int BW = DW / 8;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [4:0]    l;
  } cmd_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [BW-1:0] be;
  } wbeat_t;

  typedef struct {
    bit            rd;
    logic [AW-1:0] a;
    logic [6:0]    bc;
    int            nsub;
    logic [AW-1:0] a0, a1, a2;
    int            l0, l1, l2;
    int            cyc;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] err_flags;

  ofs_fim_emif_avmm_burst_splitter_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_W(7)
  ) s_bus ();
  ofs_fim_emif_avmm_burst_splitter_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_W(5)
  ) m_bus ();

  ofs_fim_emif_avmm_burst_splitter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .S_BURST_W(7),
    .M_MAX_BURST(16), .M_BURST_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_if(s_bus), .m_if(m_bus),
    .err_flags(err_flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_pass = 0;
  int n_total = 0;
  int hold_err = 0;
  int lat_err = 0;
  int rd_pending = 0;
  bit wait_rand = 1'b0;

  cmd_t   wr_cmds[$];
  cmd_t   rd_cmds[$];
  cmd_t   exp_cmds[$];
  wbeat_t wr_data[$];
  wbeat_t exp_wdata[$];
  logic [DW-1:0] rd_sent[$];
  logic [DW-1:0] rd_got[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [DW-1:0] rnd_w();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++)
      r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: split a burst at every 16-beat boundary.
  task automatic model(input logic [AW-1:0] a, input int n);
    int room, l;
    exp_cmds.delete();
    while (n > 0) begin
      room = 16 - int'(a % 16);
      l = (n < room) ? n : room;
      exp_cmds.push_back(cmd_t'{a, 5'(l)});
      a = a + AW'(l);
      n -= l;
    end
  endtask

  task automatic clear_q();
    wr_cmds.delete();
    rd_cmds.delete();
    wr_data.delete();
    exp_wdata.delete();
    rd_sent.delete();
    rd_got.delete();
  endtask

  // EMIF-side monitor: commands, write beats, read latency.
  int   beats_left = 0;
  cmd_t cur;
  bit   prev_rv = 1'b0;
  logic [DW-1:0] prev_rd;

  always @(negedge clk) begin
    if (!rst_n) begin
      beats_left = 0;
      prev_rv = 1'b0;
    end else begin
      if (m_bus.write && !m_bus.waitrequest) begin
        if (beats_left == 0) begin
          cur = cmd_t'{m_bus.address, m_bus.burstcount};
          wr_cmds.push_back(cur);
          beats_left = int'(m_bus.burstcount) - 1;
          if (beats_left < 0) beats_left = 0;
        end else begin
          if (m_bus.address != cur.a ||
              m_bus.burstcount != cur.l)
            hold_err++;
          beats_left--;
        end
        wr_data.push_back(
          wbeat_t'{m_bus.writedata, m_bus.byteenable});
      end
      if (m_bus.read && !m_bus.waitrequest) begin
        rd_cmds.push_back(
          cmd_t'{m_bus.address, m_bus.burstcount});
        rd_pending += int'(m_bus.burstcount);
      end
      if (prev_rv) begin
        if (!s_bus.readdatavalid) lat_err++;
        rd_got.push_back(s_bus.readdata);
      end else if (s_bus.readdatavalid) begin
        lat_err++;
      end
      prev_rv = m_bus.readdatavalid;
      prev_rd = m_bus.readdata;
    end
  end

  // EMIF-side responder: stalls and in-order read data.
  initial begin
    logic [DW-1:0] d;
    forever begin
      @(posedge clk);
      #1;
      m_bus.waitrequest = wait_rand ? 1'($urandom_range(0, 1))
                                    : 1'b0;
      if (!rst_n) begin
        rd_pending = 0;
        m_bus.readdatavalid = 1'b0;
      end else if (rd_pending > 0 &&
                   (!wait_rand || $urandom_range(0, 1) == 1)) begin
        d = rnd_w();
        m_bus.readdata = d;
        m_bus.readdatavalid = 1'b1;
        rd_sent.push_back(d);
        rd_pending--;
      end else begin
        m_bus.readdatavalid = 1'b0;
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] a,
                          input logic [6:0] bc,
                          output int cyc);
    int n, tmo;
    bit acc;
    wbeat_t b;
    logic [95:0] t;
    n = (bc == 0) ? 1 : int'(bc);
    cyc = 0;
    s_bus.address = a;
    s_bus.burstcount = bc;
    for (int i = 0; i < n; i++) begin
      t = {$urandom, $urandom, $urandom};
      b.d = rnd_w();
      b.be = t[BW-1:0];
      exp_wdata.push_back(b);
      s_bus.write = 1'b1;
      s_bus.writedata = b.d;
      s_bus.byteenable = b.be;
      tmo = 0;
      forever begin
        @(negedge clk);
        acc = !s_bus.waitrequest;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) break;
        tmo++;
        if (tmo > 500) break;
      end
      if (tmo > 500) begin
        chk("wr_timeout", 1, 0);
        break;
      end
    end
    s_bus.write = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a,
                         input logic [6:0] bc,
                         output int cyc);
    int n, tmo;
    bit acc;
    n = (bc == 0) ? 1 : int'(bc);
    cyc = 0;
    s_bus.address = a;
    s_bus.burstcount = bc;
    s_bus.read = 1'b1;
    tmo = 0;
    forever begin
      @(negedge clk);
      acc = !s_bus.waitrequest;
      @(posedge clk);
      #1;
      cyc++;
      if (acc || ++tmo > 500) break;
    end
    s_bus.read = 1'b0;
    tmo = 0;
    while (rd_got.size() < n && tmo < 3000) begin
      @(posedge clk);
      #1;
      tmo++;
    end
    if (tmo >= 3000) chk("rd_timeout", 1, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cmp_cmds(input string nm, input bit rd);
    cmd_t got[$];
    int bad;
    if (rd) got = rd_cmds;
    else got = wr_cmds;
    chk({nm, "_ncmd"}, got.size(), exp_cmds.size());
    bad = 0;
    for (int k = 0; k < got.size() && k < exp_cmds.size(); k++)
      if (got[k] != exp_cmds[k]) begin
        bad++;
        $display("  %s cmd%0d got %0d@%0h want %0d@%0h", nm, k,
                 got[k].l, got[k].a, exp_cmds[k].l, exp_cmds[k].a);
      end
    chk({nm, "_cmds"}, bad, 0);
  endtask

  task automatic cmp_data(input string nm, input bit rd,
                          input int n);
    int bad;
    bad = 0;
    if (rd) begin
      chk({nm, "_nrd"}, rd_got.size(), n);
      for (int k = 0; k < rd_got.size(); k++)
        if (k >= rd_sent.size() || rd_got[k] !== rd_sent[k])
          bad++;
    end else begin
      chk({nm, "_nwr"}, wr_data.size(), n);
      for (int k = 0; k < wr_data.size(); k++)
        if (k >= exp_wdata.size() || wr_data[k] !== exp_wdata[k])
          bad++;
    end
    chk({nm, "_data"}, bad, 0);
  endtask

  vec_t tbl[7];

  initial begin
    int cyc;
    int n;
    bit rd;
    logic [AW-1:0] a;

    tbl[0] = '{0, 27'h10,      7'd40, 3, 27'h10, 27'h20, 27'h30,
               16, 16, 8, 40};
    tbl[1] = '{1, 27'h0C,      7'd20, 2, 27'h0C, 27'h10, 27'h0,
               4, 16, 0, 1};
    tbl[2] = '{0, 27'h7FFFFFE, 7'd4,  2, 27'h7FFFFFE, 27'h0, 27'h0,
               2, 2, 0, 4};
    tbl[3] = '{1, 27'h7FFFFFE, 7'd4,  2, 27'h7FFFFFE, 27'h0, 27'h0,
               2, 2, 0, 1};
    tbl[4] = '{0, 27'h0F,      7'd2,  2, 27'h0F, 27'h10, 27'h0,
               1, 1, 0, 2};
    tbl[5] = '{1, 27'h1F,      7'd3,  2, 27'h1F, 27'h20, 27'h0,
               1, 2, 0, 1};
    tbl[6] = '{0, 27'h23,      7'd13, 1, 27'h23, 27'h0, 27'h0,
               13, 0, 0, 13};

    rst_n = 1'b0;
    s_bus.write = 1'b1;
    s_bus.read = 1'b0;
    s_bus.address = 27'h55;
    s_bus.burstcount = 7'd3;
    s_bus.writedata = '0;
    s_bus.byteenable = '0;
    m_bus.waitrequest = 1'b0;
    m_bus.readdatavalid = 1'b0;
    m_bus.readdata = '1;
    repeat (3) @(negedge clk);
    chk("rst_swait", s_bus.waitrequest, 1);
    chk("rst_mwrite", m_bus.write, 0);
    chk("rst_mread", m_bus.read, 0);
    chk("rst_maddr", m_bus.address, 0);
    chk("rst_mbc", m_bus.burstcount, 0);
    chk("rst_rvalid", s_bus.readdatavalid, 0);
    chk("rst_rdata", s_bus.readdata == '0, 1);
    chk("rst_err", err_flags, 0);
    @(posedge clk);
    #1;
    s_bus.write = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      clear_q();
      exp_cmds.delete();
      exp_cmds.push_back(cmd_t'{tbl[i].a0, 5'(tbl[i].l0)});
      if (tbl[i].nsub > 1)
        exp_cmds.push_back(cmd_t'{tbl[i].a1, 5'(tbl[i].l1)});
      if (tbl[i].nsub > 2)
        exp_cmds.push_back(cmd_t'{tbl[i].a2, 5'(tbl[i].l2)});
      if (tbl[i].rd) do_read(tbl[i].a, tbl[i].bc, cyc);
      else do_write(tbl[i].a, tbl[i].bc, cyc);
      cmp_cmds($sformatf("tbl%0d", i), tbl[i].rd);
      cmp_data($sformatf("tbl%0d", i), tbl[i].rd,
               int'(tbl[i].bc));
      chk($sformatf("tbl%0d_cyc", i), cyc, tbl[i].cyc);
    end
    chk("err_clean", err_flags, 2'b00);

    clear_q();
    do_write(27'h5, 7'd0, cyc);
    model(27'h5, 1);
    cmp_cmds("bc0", 0);
    cmp_data("bc0", 0, 1);
    chk("bc0_err", err_flags, 2'b01);

    clear_q();
    s_bus.read = 1'b1;
    do_write(27'h40, 7'd1, cyc);
    s_bus.read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model(27'h40, 1);
    cmp_cmds("rw", 0);
    cmp_data("rw", 0, 1);
    chk("rw_noread", rd_cmds.size(), 0);
    chk("rw_err", err_flags, 2'b11);

    clear_q();
    s_bus.address = '0;
    s_bus.burstcount = 7'd32;
    for (int i = 0; i < 7; i++) begin
      s_bus.write = 1'b1;
      s_bus.writedata = rnd_w();
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_mwrite", m_bus.write, 0);
    chk("midrst_swait", s_bus.waitrequest, 1);
    chk("midrst_err", err_flags, 0);
    chk("midrst_beats", wr_data.size(), 7);
    s_bus.write = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_q();
    do_write(27'h0, 7'd8, cyc);
    model(27'h0, 8);
    cmp_cmds("postrst", 0);
    cmp_data("postrst", 0, 8);
    chk("postrst_cyc", cyc, 8);

    wait_rand = 1'b1;
    for (int it = 0; it < 8; it++) begin
      clear_q();
      rd = (it % 2 == 1);
      a = AW'($urandom);
      n = 64;
      model(a, n);
      if (rd) do_read(a, 7'(n), cyc);
      else do_write(a, 7'(n), cyc);
      cmp_cmds($sformatf("rnd%0d", it), rd);
      cmp_data($sformatf("rnd%0d", it), rd, n);
    end
    wait_rand = 1'b0;

    chk("cmd_hold", hold_err, 0);
    chk("rd_latency", lat_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end
endmodule
